// File: rtl/ccu_ax_scheduler.sv
// Round-robin AW/AR address scheduler for the CCU: one outstanding read and write
// per port, range-overlap blocking across ports, one-deep registered output stage.
module ccu_ax_scheduler #(
    parameter int NoPorts      = 4,
    parameter int AxiAddrWidth = 64,
    parameter int PortIdxWidth = $clog2(NoPorts)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NoPorts-1:0]                     req_valid_i,
    output logic [NoPorts-1:0]                     req_ready_o,
    input  logic [NoPorts-1:0]                     req_write_i,
    input  logic [NoPorts-1:0][AxiAddrWidth-1:0]   req_addr_i,
    input  logic [NoPorts-1:0][7:0]                req_len_i,
    input  logic [NoPorts-1:0][2:0]                req_size_i,
    output logic                                   ccu_valid_o,
    input  logic                                   ccu_ready_i,
    output logic [PortIdxWidth-1:0]                ccu_port_o,
    output logic                                   ccu_write_o,
    output logic [AxiAddrWidth-1:0]                ccu_addr_o,
    output logic [7:0]                             ccu_len_o,
    output logic [2:0]                             ccu_size_o,
    input  logic                                   cpl_valid_i,
    input  logic [PortIdxWidth-1:0]                cpl_port_i,
    input  logic                                   cpl_write_i,
    output logic                                   cpl_err_o
);

    // One extra bit so a burst ending exactly at the top of the address space does not wrap.
    typedef logic [AxiAddrWidth:0] range_addr_t;

    function automatic range_addr_t range_start(input logic [AxiAddrWidth-1:0] addr,
                                                input logic [2:0] size);
        return {1'b0, addr & ({AxiAddrWidth{1'b1}} << size)};
    endfunction

    function automatic range_addr_t range_end(input range_addr_t start,
                                              input logic [7:0] len,
                                              input logic [2:0] size);
        range_addr_t beats;
        beats      = '0;
        beats[8:0] = {1'b0, len} + 9'd1;
        return start + (beats << size);
    endfunction

    function automatic logic overlaps(input range_addr_t a_start, input range_addr_t a_end,
                                      input range_addr_t b_start, input range_addr_t b_end);
        return (a_start < b_end) && (b_start < a_end);
    endfunction

    // Table indexed [direction][port]; direction 1 = write, 0 = read.
    logic [NoPorts-1:0]     ent_vld_q   [2];
    range_addr_t            ent_start_q [2][NoPorts];
    range_addr_t            ent_end_q   [2][NoPorts];

    logic [PortIdxWidth-1:0] rr_q;
    logic                    cpl_err_q;

    range_addr_t             req_start [NoPorts];
    range_addr_t             req_end   [NoPorts];
    logic [NoPorts-1:0]      elig;
    logic                    any_elig;
    logic [PortIdxWidth-1:0] win;
    int unsigned             rr_idx;
    logic                    load;
    logic                    cpl_hit;

    always_comb begin
        for (int unsigned i = 0; i < NoPorts; i++) begin
            req_start[i] = range_start(req_addr_i[i], req_size_i[i]);
            req_end[i]   = range_end(req_start[i], req_len_i[i], req_size_i[i]);
        end
    end

    // Writes conflict with any foreign entry; reads only with foreign writes.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NoPorts; i++) begin
            elig[i] = req_valid_i[i] && !ent_vld_q[req_write_i[i]][i];
            for (int unsigned j = 0; j < NoPorts; j++) begin
                if (j != i) begin
                    if (ent_vld_q[1][j] &&
                        overlaps(req_start[i], req_end[i], ent_start_q[1][j], ent_end_q[1][j]))
                        elig[i] = 1'b0;
                    if (req_write_i[i] && ent_vld_q[0][j] &&
                        overlaps(req_start[i], req_end[i], ent_start_q[0][j], ent_end_q[0][j]))
                        elig[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        any_elig = 1'b0;
        win      = '0;
        rr_idx   = 0;
        for (int unsigned k = 0; k < NoPorts; k++) begin
            rr_idx = (32'(rr_q) + k) % NoPorts;
            if (!any_elig && elig[rr_idx]) begin
                any_elig = 1'b1;
                win      = PortIdxWidth'(rr_idx);
            end
        end
    end

    assign load    = any_elig && (!ccu_valid_o || ccu_ready_i);
    assign cpl_hit = (32'(cpl_port_i) < NoPorts) && ent_vld_q[cpl_write_i][cpl_port_i];

    always_comb begin
        req_ready_o = '0;
        if (load)
            req_ready_o[win] = 1'b1;
    end

    // Eligibility excludes a valid own entry, so a set and a clear never hit the same slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpl_err_q <= 1'b0;
            for (int unsigned d = 0; d < 2; d++) begin
                ent_vld_q[d] <= '0;
                for (int unsigned p = 0; p < NoPorts; p++) begin
                    ent_start_q[d][p] <= '0;
                    ent_end_q[d][p]   <= '0;
                end
            end
        end else begin
            if (cpl_valid_i) begin
                if (cpl_hit)
                    ent_vld_q[cpl_write_i][cpl_port_i] <= 1'b0;
                else
                    cpl_err_q <= 1'b1;
            end
            if (load) begin
                ent_vld_q[req_write_i[win]][win]   <= 1'b1;
                ent_start_q[req_write_i[win]][win] <= req_start[win];
                ent_end_q[req_write_i[win]][win]   <= req_end[win];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else if (load) begin
            if (win == PortIdxWidth'(NoPorts - 1))
                rr_q <= '0;
            else
                rr_q <= win + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ccu_valid_o <= 1'b0;
            ccu_port_o  <= '0;
            ccu_write_o <= 1'b0;
            ccu_addr_o  <= '0;
            ccu_len_o   <= '0;
            ccu_size_o  <= '0;
        end else if (load) begin
            ccu_valid_o <= 1'b1;
            ccu_port_o  <= win;
            ccu_write_o <= req_write_i[win];
            ccu_addr_o  <= req_addr_i[win];
            ccu_len_o   <= req_len_i[win];
            ccu_size_o  <= req_size_i[win];
        end else if (ccu_ready_i) begin
            ccu_valid_o <= 1'b0;
        end
    end

    assign cpl_err_o = cpl_err_q;

endmodule

// File: tb/tb_ccu_ax_scheduler.sv
// Directed bench for ccu_ax_scheduler: a range-table model checked every cycle,
// plus literal expectations on the key scenarios.
module tb_ccu_ax_scheduler;
    localparam int NP = 4;
    localparam int AW = 64;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NP-1:0]         req_valid;
    logic [NP-1:0]         req_ready;
    logic [NP-1:0]         req_write;
    logic [NP-1:0][AW-1:0] req_addr;
    logic [NP-1:0][7:0]    req_len;
    logic [NP-1:0][2:0]    req_size;
    logic                  ccu_valid;
    logic                  ccu_ready;
    logic [1:0]            ccu_port;
    logic                  ccu_write;
    logic [AW-1:0]         ccu_addr;
    logic [7:0]            ccu_len;
    logic [2:0]            ccu_size;
    logic                  cpl_valid;
    logic [1:0]            cpl_port;
    logic                  cpl_write;
    logic                  cpl_err;

    ccu_ax_scheduler #(.NoPorts(NP), .AxiAddrWidth(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_len_i(req_len), .req_size_i(req_size),
        .ccu_valid_o(ccu_valid), .ccu_ready_i(ccu_ready), .ccu_port_o(ccu_port),
        .ccu_write_o(ccu_write), .ccu_addr_o(ccu_addr), .ccu_len_o(ccu_len),
        .ccu_size_o(ccu_size),
        .cpl_valid_i(cpl_valid), .cpl_port_i(cpl_port), .cpl_write_i(cpl_write),
        .cpl_err_o(cpl_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: in-flight byte ranges per [port][dir], round-robin pointer, output stage.
    bit [64:0]     m_st [NP][2];
    bit [64:0]     m_en [NP][2];
    bit            m_v  [NP][2];
    int            m_rr;
    bit            m_ov;
    int            m_op;
    bit            m_ow;
    bit [63:0]     m_oa;
    bit [7:0]      m_ol;
    bit [2:0]      m_os;
    bit            m_err;
    logic [NP-1:0] m_acc;
    bit [NP-1:0]   m_elig;
    logic [NP-1:0] m_ready;
    int            m_w;
    int            m_p;
    bit            m_load;
    bit [64:0]     s_i;
    bit [64:0]     e_i;

    function automatic bit [64:0] m_start(input bit [63:0] a, input int sz);
        bit [64:0] g;
        g = 65'd1 << sz;
        return {1'b0, a} - ({1'b0, a} % g);
    endfunction

    function automatic bit [64:0] m_end(input bit [64:0] st, input bit [7:0] l, input int sz);
        return st + ({57'd0, l} + 65'd1) * (65'd1 << sz);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int p = 0; p < NP; p++)
                for (int d = 0; d < 2; d++)
                    m_v[p][d] = 1'b0;
            m_rr = 0; m_ov = 1'b0; m_err = 1'b0; m_acc = '0;
            chk("rst_ccu_valid", ccu_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_cpl_err", cpl_err, 0);
            chk("rst_ccu_port", ccu_port, 0);
            chk("rst_ccu_write", ccu_write, 0);
            chk("rst_ccu_addr", ccu_addr, 0);
            chk("rst_ccu_len", ccu_len, 0);
            chk("rst_ccu_size", ccu_size, 0);
        end else begin
            m_elig = '0;
            for (int i = 0; i < NP; i++) begin
                if (req_valid[i] && !m_v[i][req_write[i]]) begin
                    s_i = m_start(req_addr[i], int'(req_size[i]));
                    e_i = m_end(s_i, req_len[i], int'(req_size[i]));
                    m_elig[i] = 1'b1;
                    for (int j = 0; j < NP; j++)
                        for (int d = 0; d < 2; d++)
                            if (j != i && m_v[j][d] && (d == 1 || req_write[i]) &&
                                s_i < m_en[j][d] && m_st[j][d] < e_i)
                                m_elig[i] = 1'b0;
                end
            end
            m_w = -1;
            for (int k = 0; k < NP; k++) begin
                m_p = (m_rr + k) % NP;
                if (m_w < 0 && m_elig[m_p]) m_w = m_p;
            end
            m_load  = (m_w >= 0) && (!m_ov || ccu_ready);
            m_ready = '0;
            if (m_load) m_ready[m_w] = 1'b1;

            chk("req_ready", req_ready, m_ready);
            chk("ccu_valid", ccu_valid, m_ov);
            chk("cpl_err", cpl_err, m_err);
            if (m_ov) begin
                chk("ccu_port", ccu_port, m_op);
                chk("ccu_write", ccu_write, m_ow);
                chk("ccu_addr", ccu_addr, m_oa);
                chk("ccu_len", ccu_len, m_ol);
                chk("ccu_size", ccu_size, m_os);
            end

            if (cpl_valid) begin
                if (m_v[cpl_port][cpl_write]) m_v[cpl_port][cpl_write] = 1'b0;
                else m_err = 1'b1;
            end
            if (m_load) begin
                m_v[m_w][req_write[m_w]]  = 1'b1;
                m_st[m_w][req_write[m_w]] = m_start(req_addr[m_w], int'(req_size[m_w]));
                m_en[m_w][req_write[m_w]] = m_end(m_st[m_w][req_write[m_w]], req_len[m_w],
                                                  int'(req_size[m_w]));
                m_ov = 1'b1; m_op = m_w; m_ow = req_write[m_w];
                m_oa = req_addr[m_w]; m_ol = req_len[m_w]; m_os = req_size[m_w];
                m_rr = (m_w + 1) % NP;
            end else if (m_ov && ccu_ready) begin
                m_ov = 1'b0;
            end
            m_acc = m_ready;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            req_valid = req_valid & ~m_acc;
        end
    endtask

    task automatic post(input int p, input bit w, input logic [63:0] a,
                        input logic [7:0] l, input logic [2:0] s);
        req_write[p] = w; req_addr[p] = a; req_len[p] = l; req_size[p] = s;
        req_valid[p] = 1'b1;
    endtask

    task automatic cpl(input int p, input bit w);
        cpl_valid = 1'b1; cpl_port = 2'(p); cpl_write = w;
        step(1);
        cpl_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
        req_size = '0; ccu_ready = 1'b1; cpl_valid = 1'b0; cpl_port = '0; cpl_write = 1'b0;
        step(3);
        chk("lit_rst_valid", ccu_valid, 0);
        rst = 1'b0;

        // First grant after reset
        post(2, 0, 64'h40, 0, 3);
        #1 chk("lit_first_ready", req_ready, 4'b0100);
        step(1);
        chk("lit_first_valid", ccu_valid, 1);
        chk("lit_first_port", ccu_port, 2);
        chk("lit_first_addr", ccu_addr, 64'h40);
        cpl(2, 0);

        // Write/read conflict, released one cycle after completion
        post(0, 1, 64'h1000, 3, 3);
        step(1);
        chk("lit_conf_wport", ccu_port, 0);
        chk("lit_conf_wdir", ccu_write, 1);
        post(1, 0, 64'h1010, 0, 3);
        #1 chk("lit_conf_stall", req_ready, 0);
        step(3);
        chk("lit_conf_stall3", req_ready, 0);
        cpl_valid = 1'b1; cpl_port = 2'd0; cpl_write = 1'b1;
        #1 chk("lit_cpl_same_cycle", req_ready, 0);
        step(1);
        cpl_valid = 1'b0;
        #1 chk("lit_cpl_next_cycle", req_ready, 4'b0010);
        step(1);
        chk("lit_conf_rport", ccu_port, 1);
        chk("lit_conf_raddr", ccu_addr, 64'h1010);
        cpl(1, 0);

        // Adjacent ranges do not block
        post(0, 1, 64'h1000, 3, 3);
        step(1);
        post(1, 1, 64'h1020, 0, 3);
        #1 chk("lit_adj_ready", req_ready, 4'b0010);
        step(1);
        chk("lit_adj_addr", ccu_addr, 64'h1020);
        cpl(0, 1);
        cpl(1, 1);

        // Bring rr to 0, then round-robin 0..3 and wrap
        post(3, 0, 64'h9000, 0, 3);
        step(1);
        chk("lit_rr_setup", ccu_port, 3);
        cpl(3, 0);
        for (int i = 0; i < NP; i++) post(i, 0, 64'h2000 + 64'(i) * 64'h100, 0, 3);
        for (int i = 0; i < NP; i++) begin
            step(1);
            chk("lit_rr_port", ccu_port, i);
            chk("lit_rr_valid", ccu_valid, 1);
        end
        for (int i = 0; i < NP; i++) cpl(i, 0);
        post(0, 0, 64'h2400, 0, 3);
        post(1, 0, 64'h2500, 0, 3);
        step(1);
        chk("lit_rr_wrap0", ccu_port, 0);
        step(1);
        chk("lit_rr_wrap1", ccu_port, 1);
        cpl(0, 0);
        cpl(1, 0);

        // Backpressure
        ccu_ready = 1'b0;
        post(2, 0, 64'h3000, 0, 3);
        step(1);
        post(3, 0, 64'h3100, 0, 3);
        repeat (3) begin
            #1;
            chk("lit_bp_ready", req_ready, 0);
            chk("lit_bp_port", ccu_port, 2);
            chk("lit_bp_addr", ccu_addr, 64'h3000);
            step(1);
        end
        ccu_ready = 1'b1;
        #1 chk("lit_bp_release", req_ready, 4'b1000);
        step(1);
        chk("lit_bp_next", ccu_addr, 64'h3100);
        step(1);
        chk("lit_bp_drain", ccu_valid, 0);
        cpl(2, 0);
        cpl(3, 0);

        // Top of address space, spurious completion
        post(0, 1, 64'hFFFF_FFFF_FFFF_FFC0, 7, 3);
        step(1);
        chk("lit_top_addr", ccu_addr, 64'hFFFF_FFFF_FFFF_FFC0);
        post(1, 0, 64'h0, 0, 3);
        #1 chk("lit_top_zero", req_ready, 4'b0010);
        step(1);
        post(2, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 3);
        #1 chk("lit_top_block", req_ready, 0);
        step(2);
        req_valid[2] = 1'b0;
        cpl(3, 0);
        chk("lit_err_set", cpl_err, 1);
        step(2);
        chk("lit_err_sticky", cpl_err, 1);

        // Reset mid-operation discards table and output stage
        rst = 1'b1;
        #1;
        chk("lit_mid_rst_valid", ccu_valid, 0);
        chk("lit_mid_rst_err", cpl_err, 0);
        step(2);
        rst = 1'b0;
        post(2, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 3);
        #1 chk("lit_post_rst_ready", req_ready, 4'b0100);
        step(1);
        chk("lit_post_rst_port", ccu_port, 2);
        cpl(2, 0);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ccu_ax_scheduler.md
# ccu_ax_scheduler

Arbitrates AW/AR address requests from `NoPorts` coherent masters onto the single address channel of the cache-coherency unit (CCU). It tracks at most one outstanding read and one outstanding write per port, and blocks any request whose byte range overlaps an in-flight range of another port. Eligible requests are granted round-robin through a one-deep registered output stage. It sits between the per-core AXI/ACE ports and the CCU snoop/dispatch logic.

## Interface
- `NoPorts`, 4: number of requesting ports, 2..16.
- `AxiAddrWidth`, 64: address width.
- `PortIdxWidth`, `$clog2(NoPorts)`: port index width (derived).

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  NoPorts  per-port request valid.
- `req_ready_o`  out  NoPorts  per-port request accepted.
- `req_write_i`  in  NoPorts  1 = AW (write), 0 = AR (read).
- `req_addr_i`  in  NoPorts×AxiAddrWidth  AxADDR.
- `req_len_i`  in  NoPorts×8  AxLEN.
- `req_size_i`  in  NoPorts×3  AxSIZE.
- `ccu_valid_o`  out  1  granted request valid towards the CCU.
- `ccu_ready_i`  in  1  CCU accepts.
- `ccu_port_o`  out  PortIdxWidth  index of the originating port.
- `ccu_write_o`, `ccu_addr_o`, `ccu_len_o`, `ccu_size_o`  out  1/AxiAddrWidth/8/3  granted request fields, unmodified.
- `cpl_valid_i`  in  1  transaction completion pulse (B handshake, or last R beat).
- `cpl_port_i`  in  PortIdxWidth  completing port.
- `cpl_write_i`  in  1  completing direction.
- `cpl_err_o`  out  1  sticky flag: completion received for a non-valid entry.

## Operation
- Range per request:
  - `start = addr & ~((1<<size)-1)`.
  - `end = start + ((len+1) << size)`, computed in AxiAddrWidth+1 bits so there is no wrap.
  - The range is half-open: `[start, end)`.
- Table: per port, one read entry and one write entry, each holding {valid, start, end}.
- Overlap between two ranges a and b: `a.start < b.end && b.start < a.end`. Adjacent ranges do not overlap.
- Port i is eligible when all of the following hold:
  - `req_valid_i[i]` is high.
  - Its own entry for the requested direction is not valid.
  - No overlap with any valid entry of another port j≠i:
    - a write is checked against both read and write entries;
    - a read is checked against write entries only.
- Load condition: `load = any_eligible && (!ccu_valid_o || ccu_ready_i)`.
- Arbitration: round-robin over eligible ports, starting at pointer `rr_q`.
- On load of winner w:
  - `req_ready_o[w]=1`; all other `req_ready_o` bits are 0.
  - The output stage captures w's fields.
  - w's entry for the requested direction is set valid with {start, end}.
  - `rr_q` becomes `(w+1) mod NoPorts`.
- If the output stage handshakes (`ccu_valid_o && ccu_ready_i`) and there is no load, `ccu_valid_o` goes to 0.
- Completion: `cpl_valid_i` clears entry `[cpl_port_i][cpl_write_i]`.
  - If that entry is already invalid, nothing changes and `cpl_err_o` is set until reset.
- Eligibility uses registered table state only. A same-cycle completion unblocks requests on the next cycle, never the same cycle.
- Set and clear can hit the same entry only if it were valid and granted, which eligibility forbids. No priority rule is needed.

## Timing
- Reset values:
  - `ccu_valid_o=0`, `req_ready_o=0`, `cpl_err_o=0`.
  - All table entries invalid, `rr_q=0`.
  - Output fields are 0.
- Reset asserted mid-operation discards the table and the output stage immediately.
- Latency: request accepted in cycle t appears on `ccu_*` in cycle t+1.
- Throughput: one grant per cycle while `ccu_ready_i=1`.
- While `ccu_valid_o=1 && ccu_ready_i=0`, all `ccu_*` outputs are stable and all `req_ready_o` are 0.
- `req_ready_o` is combinational from `req_valid_i`, the request fields, registered state, and `ccu_ready_i`.
- The request fields may change while `req_ready_o[i]=0`.

## Test plan
- Reset: with `rst_i` high and then released, every output is 0. A read on port 2 at 0x40 is the first grant and is loaded in the cycle after `req_valid_i`.
- Write/read conflict:
  - Port 0 writes addr 0x1000, len 3, size 3, giving range [0x1000,0x1020).
  - Port 1 reads 0x1010 and stalls with `req_ready_o[1]=0`.
  - `cpl_valid_i` is pulsed for port 0 write in cycle t; port 1 is granted in cycle t+1.
- Adjacent ranges: port 0 has a write in flight at [0x1000,0x1020). Port 1 writes 0x1020, len 0, size 3 and is granted without stall.
- Round-robin: ports 0–3 issue non-overlapping reads with `ccu_ready_i=1`. `ccu_port_o` sequence is 0,1,2,3 on consecutive cycles. A following port 0 request is granted after `rr_q` wraps.
- Backpressure: `ccu_ready_i=0` for 3 cycles with a grant pending. `ccu_*` outputs are unchanged and `req_ready_o=0`. On release, the next port is loaded in the same cycle as the handshake.
- Top of address space and spurious completion:
  - A write at 0xFFFF_FFFF_FFFF_FFC0, len 7, size 3 gives end=2^64.
  - A read from another port at 0x0 is not blocked.
  - `cpl_valid_i` for an idle port 3 read sets `cpl_err_o=1`, and it stays set until reset.
